// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bundle between the core's data port and the responder.
interface data_mem_responder_if;
    logic        readEnable;
    logic        writeEnable;
    logic [3:0]  readByteSelect;
    logic [3:0]  writeByteSelect;
    logic [2:0]  loadSelect;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        ready;
    logic        busy;
    logic        fault;

    modport master (
        output readEnable, writeEnable, readByteSelect, writeByteSelect,
               loadSelect, address, dataIn,
        input  dataOut, ready, busy, fault
    );

    modport slave (
        input  readEnable, writeEnable, readByteSelect, writeByteSelect,
               loadSelect, address, dataIn,
        output dataOut, ready, busy, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-RAM responder: latches one load/store, waits WAIT_STATES cycles, checks legality,
// performs the byte-lane access and answers with a one-cycle ready (plus fault on reject).
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic        op_rd, op_wr;
    logic [3:0]  rsel_q, wsel_q;
    logic [2:0]  lsel_q;
    logic [31:0] addr_q, data_q;
    logic        fault_q;
    logic [31:0] dout_q;
    logic [31:0] mem [DEPTH];

    logic                  request;
    logic [31:0]           off;
    logic [1:0]            lo;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic [2:0]            wwidth, rwidth, lwidth;
    logic                  legal;
    logic [31:0]           word_rd, shifted, load_val, wdata;

    // Returns the access width in bytes for a lane mask at this alignment, 0 if illegal.
    function automatic logic [2:0] lane_width(input logic [3:0] sel, input logic [1:0] low);
        lane_width = 3'd0;
        if (sel == (4'b0001 << low))
            lane_width = 3'd1;
        else if ((sel == 4'b0011 && low == 2'd0) || (sel == 4'b1100 && low == 2'd2))
            lane_width = 3'd2;
        else if (sel == 4'b1111 && low == 2'd0)
            lane_width = 3'd4;
    endfunction

    assign request = bus.readEnable | bus.writeEnable;

    always_comb begin
        off      = addr_q - BASE_ADDR;
        lo       = off[1:0];
        idx      = off[ADDR_WIDTH+1:2];
        in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;
        wwidth   = lane_width(wsel_q, lo);
        rwidth   = lane_width(rsel_q, lo);
        case (lsel_q)
            3'b000, 3'b100: lwidth = 3'd1;
            3'b001, 3'b101: lwidth = 3'd2;
            3'b010:         lwidth = 3'd4;
            default:        lwidth = 3'd0;
        endcase
        legal = in_range && (op_rd != op_wr) &&
                (op_wr ? (wwidth != 3'd0) : (rwidth != 3'd0 && rwidth == lwidth));

        word_rd = mem[idx];
        shifted = word_rd >> {lo, 3'b000};
        case (lsel_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
        wdata = data_q << {lo, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_cnt == 4'd0) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            dout_q   <= '0;
        end else begin
            case (state)
                IDLE:   if (request) wait_cnt <= WAIT_LOAD;
                WAIT:   if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                ACCESS: begin
                    fault_q <= !legal;
                    // Faulted loads zero the result; stores never touch it.
                    if (op_rd && !op_wr) dout_q <= legal ? load_val : '0;
                end
                default: ;
            endcase
        end
    end

    // Request fields are only captured in IDLE, so requests while busy leave them intact.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && request) begin
            op_rd  <= bus.readEnable;
            op_wr  <= bus.writeEnable;
            rsel_q <= bus.readByteSelect;
            wsel_q <= bus.writeByteSelect;
            lsel_q <= bus.loadSelect;
            addr_q <= bus.address;
            data_q <= bus.dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && legal && op_wr) begin
            for (int unsigned i = 0; i < 4; i++)
                if (wsel_q[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign bus.ready   = (state == RESP);
    assign bus.fault   = (state == RESP) && fault_q;
    assign bus.busy    = (state != IDLE);
    assign bus.dataOut = dout_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder (WAIT_STATES=2 and 0) against a byte-array reference model.
module tb_data_mem_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .bus(bus_a));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus_b));

    int          dut_sel = 0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  rsel_v = '0, wsel_v = '0;
    logic [2:0]  lsel_v = '0;
    logic [31:0] addr_v = '0, din_v = '0;

    assign bus_a.readEnable      = rd_en && dut_sel == 0;
    assign bus_a.writeEnable     = wr_en && dut_sel == 0;
    assign bus_b.readEnable      = rd_en && dut_sel == 1;
    assign bus_b.writeEnable     = wr_en && dut_sel == 1;
    assign bus_a.readByteSelect  = rsel_v;
    assign bus_b.readByteSelect  = rsel_v;
    assign bus_a.writeByteSelect = wsel_v;
    assign bus_b.writeByteSelect = wsel_v;
    assign bus_a.loadSelect      = lsel_v;
    assign bus_b.loadSelect      = lsel_v;
    assign bus_a.address         = addr_v;
    assign bus_b.address         = addr_v;
    assign bus_a.dataIn          = din_v;
    assign bus_b.dataIn          = din_v;

    logic        obs_ready, obs_busy, obs_fault;
    logic [31:0] obs_dout;
    assign obs_ready = dut_sel == 1 ? bus_b.ready   : bus_a.ready;
    assign obs_busy  = dut_sel == 1 ? bus_b.busy    : bus_a.busy;
    assign obs_fault = dut_sel == 1 ? bus_b.fault   : bus_a.fault;
    assign obs_dout  = dut_sel == 1 ? bus_b.dataOut : bus_a.dataOut;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte-addressed RAM per DUT plus the last reported load result.
    logic [7:0]  ref_mem [2][4096];
    logic [31:0] ref_dout [2];

    task automatic model_op(input int w, input bit rd, input bit wr, input logic [3:0] rsel,
                            input logic [3:0] wsel, input logic [2:0] lsel, input logic [31:0] addr,
                            input logic [31:0] din, output bit flt, output logic [31:0] dout);
        int unsigned off, lo, sz, lsz;
        bit          ok;
        logic [3:0]  sel;
        logic [31:0] v;
        off = addr - BASE;
        lo  = off % 4;
        sel = wr ? wsel : rsel;
        sz  = $countones(sel);
        ok  = (off < 4096) && (rd != wr) && (sz == 1 || sz == 2 || sz == 4);
        if (ok) ok = (lo % sz == 0) && (int'(sel) == (((1 << sz) - 1) << lo));
        if (rd && !wr) begin
            case (lsel)
                3'd0, 3'd4: lsz = 1;
                3'd1, 3'd5: lsz = 2;
                3'd2:       lsz = 4;
                default:    lsz = 0;
            endcase
            ok = ok && (lsz == sz);
        end
        flt = !ok;
        if (ok && wr)
            for (int unsigned k = 0; k < sz; k++) ref_mem[w][off + k] = din[8*k +: 8];
        if (rd && !wr) begin
            v = '0;
            if (ok) begin
                for (int unsigned k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[w][off + k];
                if (!lsel[2] && sz < 4 && v[8*sz - 1]) v = v | (32'hFFFF_FFFF << (8*sz));
            end
            ref_dout[w] = v;
        end
        dout = ref_dout[w];
    endtask

    // One transaction, started and finished on a falling edge with the DUT idle.
    task automatic xact(input int w, input bit rd, input bit wr, input logic [3:0] rsel,
                        input logic [3:0] wsel, input logic [2:0] lsel, input logic [31:0] addr,
                        input logic [31:0] din, input bit noise);
        bit          ef;
        logic [31:0] ed;
        int          n, lat, ws;
        ws = (w == 1) ? 0 : 2;
        model_op(w, rd, wr, rsel, wsel, lsel, addr, din, ef, ed);
        dut_sel = w;
        rd_en = rd; wr_en = wr; rsel_v = rsel; wsel_v = wsel;
        lsel_v = lsel; addr_v = addr; din_v = din;
        @(posedge clk);
        n = 0; lat = 0;
        while (lat == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (obs_ready) lat = n;
            else begin
                check_eq("busy_inflight", {31'd0, obs_busy}, 32'd1);
                if (noise) begin
                    rd_en = 1'($urandom); wr_en = 1'($urandom);
                    rsel_v = 4'($urandom); wsel_v = 4'($urandom); lsel_v = 3'($urandom);
                    addr_v = BASE + ($urandom % 128); din_v = $urandom;
                end else begin
                    rd_en = 1'b0; wr_en = 1'b0;
                end
            end
        end
        rd_en = 1'b0; wr_en = 1'b0;
        if (lat == 0) begin
            check_eq("ready_timeout", {31'd0, obs_ready}, 32'd1);
            return;
        end
        check_eq("latency", lat, ws + 2);
        check_eq("busy_ready", {31'd0, obs_busy}, 32'd1);
        check_eq("fault", {31'd0, obs_fault}, {31'd0, ef});
        check_eq("dataOut", obs_dout, ed);
        @(negedge clk);
        check_eq("ready_pulse", {31'd0, obs_ready}, 32'd0);
        check_eq("busy_clear", {31'd0, obs_busy}, 32'd0);
        check_eq("fault_pulse", {31'd0, obs_fault}, 32'd0);
    endtask

    task automatic rand_op(input int w);
        int unsigned k, sz, lo, wo, r;
        bit          st;
        logic [3:0]  mask, rsel, wsel;
        logic [2:0]  lsel;
        logic [31:0] addr;
        bit          rd, wr;
        r    = $urandom_range(0, 11);
        k    = $urandom_range(0, 2);
        sz   = 1 << k;
        lo   = $urandom_range(0, 3) & ~(sz - 1);
        wo   = $urandom_range(0, 31);
        addr = BASE + wo * 4 + lo;
        mask = 4'(((1 << sz) - 1) << lo);
        st   = 1'($urandom);
        lsel = {(k == 2) ? 1'b0 : 1'($urandom), 2'(k)};
        rsel = st ? 4'($urandom) : mask;
        wsel = st ? mask : 4'($urandom);
        rd = !st; wr = st;
        case (r)
            0: begin rsel = 4'($urandom); wsel = 4'($urandom); end
            1: lsel = 3'($urandom);
            2: begin rd = 1'b1; wr = 1'b1; end
            3: addr = (($urandom & 1) != 0) ? BASE - 4 * $urandom_range(1, 8) + lo
                                             : BASE + 4096 + 4 * $urandom_range(0, 8) + lo;
            default: ;
        endcase
        xact(w, rd, wr, rsel, wsel, lsel, addr, $urandom, 1'($urandom));
    endtask

    task automatic hold_test();
        bit          ef;
        logic [31:0] ed;
        int          pulses;
        model_op(0, 1'b1, 1'b0, 4'hF, 4'h0, 3'd2, BASE + 4, 32'd0, ef, ed);
        dut_sel = 0;
        rd_en = 1'b1; wr_en = 1'b0; rsel_v = 4'hF; wsel_v = 4'h0; lsel_v = 3'd2; addr_v = BASE + 4;
        pulses = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            check_eq("hold_ready", {31'd0, obs_ready}, {31'd0, (c % 5) == 4});
            check_eq("hold_busy", {31'd0, obs_busy}, {31'd0, (c % 5) != 0});
            if (obs_ready) begin
                check_eq("hold_data", obs_dout, ed);
                check_eq("hold_fault", {31'd0, obs_fault}, {31'd0, ef});
                pulses++;
                if (pulses == 3) begin
                    rd_en = 1'b0;
                    break;
                end
            end
        end
        check_eq("hold_pulses", pulses, 3);
        @(negedge clk);
        check_eq("hold_idle", {31'd0, obs_busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {31'd0, bus_a.ready}, 32'd0);
        check_eq("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        check_eq("rst_fault", {31'd0, bus_a.fault}, 32'd0);
        check_eq("rst_dout", bus_a.dataOut, 32'd0);
        check_eq("rst_dout0", bus_b.dataOut, 32'd0);
        check_eq("rst_busy0", {31'd0, bus_b.busy}, 32'd0);
        ref_dout[0] = '0; ref_dout[1] = '0;
        rst = 1'b0;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 32; i++)
                xact(w, 1'b0, 1'b1, 4'h0, 4'hF, 3'd2, BASE + 4 * i, $urandom, 1'b0);

        xact(0, 0, 1, 4'h0, 4'hF, 3'd2, 32'h1004, 32'hDEAD_BEEF, 0);
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1004, 32'h0, 0);
        check_eq("lw_word", obs_dout, 32'hDEAD_BEEF);
        xact(0, 0, 1, 4'h0, 4'h4, 3'd0, 32'h1006, 32'h0000_00A5, 1);
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1004, 32'h0, 0);
        check_eq("lw_after_sb", obs_dout, 32'hDEA5_BEEF);
        xact(0, 1, 0, 4'h4, 4'h0, 3'd0, 32'h1006, 32'h0, 0);
        check_eq("lb", obs_dout, 32'hFFFF_FFA5);
        xact(0, 1, 0, 4'h4, 4'h0, 3'd4, 32'h1006, 32'h0, 0);
        check_eq("lbu", obs_dout, 32'h0000_00A5);
        xact(0, 0, 1, 4'h0, 4'hC, 3'd1, 32'h1002, 32'h0000_1234, 0);
        xact(0, 1, 0, 4'hC, 4'h0, 3'd1, 32'h1002, 32'h0, 0);
        check_eq("lh", obs_dout, 32'h0000_1234);
        xact(0, 0, 1, 4'h0, 4'h3, 3'd1, 32'h1000, 32'h0000_8001, 0);
        xact(0, 1, 0, 4'h3, 4'h0, 3'd5, 32'h1000, 32'h0, 0);
        check_eq("lhu", obs_dout, 32'h0000_8001);
        xact(0, 1, 0, 4'h3, 4'h0, 3'd1, 32'h1000, 32'h0, 0);
        check_eq("lh_neg", obs_dout, 32'hFFFF_8001);
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1002, 32'h0, 0);
        xact(0, 0, 1, 4'h0, 4'hF, 3'd2, 32'h0FFC, 32'h5555_5555, 0);
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1000 + 4 * 1024, 32'h0, 0);
        xact(0, 1, 1, 4'hF, 4'hF, 3'd2, 32'h1004, 32'h7777_7777, 0);
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1004, 32'h0, 0);
        check_eq("ram_unchanged", obs_dout, 32'hDEA5_BEEF);

        hold_test();

        xact(0, 0, 1, 4'h0, 4'hF, 3'd2, 32'h1008, 32'hCAFE_F00D, 0);
        dut_sel = 0;
        rd_en = 1'b0; wr_en = 1'b1; wsel_v = 4'hF; addr_v = 32'h1008; din_v = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_pre_busy", {31'd0, obs_busy}, 32'd1);
        wr_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, obs_ready}, 32'd0);
        check_eq("rst_mid_fault", {31'd0, obs_fault}, 32'd0);
        check_eq("rst_mid_dout", obs_dout, 32'd0);
        ref_dout[0] = '0; ref_dout[1] = '0;
        xact(0, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1008, 32'h0, 0);
        check_eq("rst_drop_store", obs_dout, 32'hCAFE_F00D);

        xact(1, 0, 1, 4'h0, 4'hF, 3'd2, 32'h1008, 32'h1357_9BDF, 0);
        xact(1, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1008, 32'h0, 0);
        xact(1, 1, 0, 4'hF, 4'h0, 3'd2, 32'h1006, 32'h0, 0);

        repeat (150) rand_op(0);
        repeat (60) rand_op(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-memory request interface, with wait states.
- Accepts one load/store request per transaction using the core's enable, byte-select, loadSelect, address and dataIn signals.
- Performs byte-lane writes, or reads with sign/zero extension, and signals completion with a one-cycle ready pulse.
- Flags misaligned, out-of-range or illegal accesses with a fault pulse. Sits between the core's data port and on-chip data RAM.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 2, extra cycles inserted before each access completes (0..15).
- BASE_ADDR, 32'h0000_1000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- readEnable  input  1  load request.
- writeEnable  input  1  store request.
- readByteSelect  input  4  byte lanes for a load.
- writeByteSelect  input  4  byte lanes for a store.
- loadSelect  input  3  funct3 of the load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- address  input  32  byte address.
- dataIn  input  32  store data, right-justified: SB uses [7:0], SH uses [15:0].
- dataOut  output  32  extended load result; held until the next load completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from the accept edge until the ready cycle, inclusive.
- fault  output  1  one-cycle pulse coincident with ready when the access was rejected.

Behaviour:
- Reset values: dataOut=0, ready=0, fault=0, busy=0, state=IDLE, wait counter=0. RAM contents are not cleared by rst.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If readEnable|writeEnable, latch address, dataIn, both selects, loadSelect and the op; set busy.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle. Leave for ACCESS when the counter is 0.
- ACCESS: legality check; RAM write or read; result registered.
- RESP: ready=1 for one cycle, plus fault if the access was rejected. Then return to IDLE, clear busy.
- Latency: ready is high exactly WAIT_STATES+2 cycles after the accepting edge.
- Back-to-back: a request held high on the RESP cycle is not accepted. It is accepted on the following IDLE cycle.
- Requests while busy are ignored and do not alter latched values.
- Let off = address-BASE_ADDR. The access is legal only if all of these hold:
  - off < 4*2**ADDR_WIDTH (unsigned; address<BASE_ADDR wraps to large and faults).
  - Exactly one of readEnable/writeEnable is set.
  - For a store, writeByteSelect is one of:
    - 0001<<off[1:0] (byte);
    - 0011 with off[1:0]=00, or 1100 with off[1:0]=10 (half);
    - 1111 with off[1:0]=00 (word).
  - For a load, the same rule applies to readByteSelect, and loadSelect is one of the five legal codes and matches the select width.
- Store: dataIn is shifted left by 8*off[1:0]. Only the selected lanes of word off[ADDR_WIDTH+1:2] are written.
- Load: the selected lanes are shifted down to bit 0, then extended as loadSelect specifies. The result appears on dataOut in the RESP cycle.
- Fault:
  - RAM is unchanged; dataOut is unchanged for a faulted store and set to 0 for a faulted load.
  - ready and fault both pulse in the same cycle.
- Both enables high at accept is a fault; no RAM write occurs.
- rst asserted in any state forces IDLE and all outputs to their reset values on that edge. An in-flight store that has not reached ACCESS is dropped.

Test Plan:
- SW 0xDEADBEEF to 0x1004 (sel 1111, WAIT_STATES=2), then LW 0x1004 -> ready exactly 4 cycles after each accept; dataOut=0xDEADBEEF; fault=0.
- Byte and half loads after the word above:
  - SB dataIn=0x000000A5 to 0x1006 (sel 0100), then LW 0x1004 -> 0xDEA5BEEF.
  - LB 0x1006 -> 0xFFFFFFA5; LBU 0x1006 -> 0x000000A5.
- SH 0x00001234 to 0x1002 (sel 1100), then LH 0x1002 -> 0x00001234. LHU of 0x8001 stored at 0x1000 -> 0x00008001; LH -> 0xFFFF8001.
- Illegal accesses -> fault=1 with ready, RAM unchanged, faulted LW gives dataOut=0:
  - LW 0x1002 (misaligned);
  - SW 0x0FFC (below base);
  - LW 0x1000+4*1024 (above range);
  - readEnable and writeEnable both high.
- Hold readEnable continuously -> accepts spaced WAIT_STATES+3 cycles apart; enable toggles during WAIT are ignored; busy is high from the accept edge through the ready cycle.
- Assert rst during WAIT of SW 0x11111111 to 0x1008 -> next cycle busy=0, ready=0; later LW 0x1008 returns the prior value. Repeat with WAIT_STATES=0 -> ready 2 cycles after accept.
